// File: rtl/board_scanner.sv
// Sweeps the tetris playfield through the cell-query port into a back bank,
// then flips banks so the renderer always reads a complete snapshot.
module board_scanner #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int TYPE_W = 3,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [3:0]        x,
  output logic [4:0]        y,
  input  logic [TYPE_W-1:0] cell_type,
  input  logic [3:0]        rd_x,
  input  logic [4:0]        rd_y,
  output logic [TYPE_W-1:0] rd_type,
  output logic              busy,
  output logic              done
);

  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    SWAP
  } state_t;

  state_t state, state_nx;

  logic          front_sel;
  logic          pending;
  logic [1:0]    dcnt;
  logic          last_q;
  logic          q_v;
  logic [AW-1:0] q_a;
  logic          wr_v;
  logic [AW-1:0] wr_a;
  logic          rd_ok;
  logic [AW-1:0] ra;

  logic [TYPE_W-1:0] bank [2][N];

  assign last_q = (x == 4'(COLS - 1)) && (y == 5'(ROWS - 1));
  assign busy   = (state != IDLE);
  assign done   = (state == SWAP);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (last_q) state_nx = (LAT == 0) ? SWAP : DRAIN;
      DRAIN:   if (dcnt == 2'(LAT - 1)) state_nx = SWAP;
      SWAP:    state_nx = (pending || start) ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      dcnt      <= '0;
      front_sel <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SCAN) begin
        if (x == 4'(COLS - 1)) begin
          x <= '0;
          y <= last_q ? '0 : y + 5'd1;
        end else begin
          x <= x + 4'd1;
        end
      end else begin
        x <= '0;
        y <= '0;
      end
      dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      if (state == SWAP) front_sel <= ~front_sel;
      if (state == SWAP)
        pending <= 1'b0;
      else if (start && state != IDLE)
        pending <= 1'b1;
    end
  end

  // Query address travels alongside the core's response latency.
  assign q_v = (state == SCAN);
  assign q_a = AW'(32'(y) * COLS + 32'(x));

  generate
    if (LAT == 0) begin : g_direct
      assign wr_v = q_v;
      assign wr_a = q_a;
    end else begin : g_pipe
      logic [LAT-1:0] pv;
      logic [AW-1:0]  pa [LAT];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pv <= '0;
        end else begin
          pv[0] <= q_v;
          for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pa[0] <= q_a;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
      end

      assign wr_v = pv[LAT-1];
      assign wr_a = pa[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_v) bank[~front_sel][wr_a] <= cell_type;
  end

  assign rd_ok = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
  assign ra    = AW'(32'(rd_y) * COLS + 32'(rd_x));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_type <= '0;
    else
      rd_type <= rd_ok ? bank[front_sel][ra] : '0;
  end

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner with LAT=1 main instance
// plus LAT=0 and LAT=3 instances driven from the same stimulus.
module tb_board_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] rd_x;
  logic [4:0] rd_y;
  logic       mode;

  logic [3:0] x1, x0, x3;
  logic [4:0] y1, y0, y3;
  logic [2:0] t1, t0, t3, s3a, s3b;
  logic [2:0] r1, r0, r3;
  logic       busy1, busy0, busy3;
  logic       done1, done0, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] cell_f(input logic m,
                                        input logic [3:0] xx,
                                        input logic [4:0] yy);
    return m ? 3'd7 : 3'(int'(xx) + int'(yy));
  endfunction

  assign t0 = cell_f(mode, x0, y0);

  always @(posedge clk) begin
    t1  <= cell_f(mode, x1, y1);
    s3a <= cell_f(mode, x3, y3);
    s3b <= s3a;
    t3  <= s3b;
  end

  board_scanner #(.LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x(x1), .y(y1), .cell_type(t1),
    .rd_x(rd_x), .rd_y(rd_y), .rd_type(r1),
    .busy(busy1), .done(done1)
  );

  board_scanner #(.LAT(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x(x0), .y(y0), .cell_type(t0),
    .rd_x(rd_x), .rd_y(rd_y), .rd_type(r0),
    .busy(busy0), .done(done0)
  );

  board_scanner #(.LAT(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x(x3), .y(y3), .cell_type(t3),
    .rd_x(rd_x), .rd_y(rd_y), .rd_type(r3),
    .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy0 || busy3) && n < 1200) begin
      tick();
      n++;
    end
    chk("idle", {31'd0, busy1 | busy0 | busy3}, 0);
  endtask

  task automatic scan(output int d1, output int d0, output int d3);
    start = 1'b1;
    tick();
    start = 1'b0;
    d1 = 0;
    d0 = 0;
    d3 = 0;
    for (int c = 1; c <= 400; c++) begin
      if (done1 && d1 == 0) d1 = c;
      if (done0 && d0 == 0) d0 = c;
      if (done3 && d3 == 0) d3 = c;
      if (d1 != 0 && d0 != 0 && d3 != 0) break;
      tick();
    end
  endtask

  task automatic rd(input int cx, input int cy);
    rd_x = 4'(cx);
    rd_y = 5'(cy);
    tick();
  endtask

  initial begin
    int d1, d0, d3, da, db;
    logic bad;

    reset_n = 1'b0;
    start   = 1'b0;
    rd_x    = '0;
    rd_y    = '0;
    mode    = 1'b0;
    repeat (3) tick();

    chk("rst_x", x1, 0);
    chk("rst_y", y1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rd", r1, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_busy", busy1, 0);
    chk("rel_xy", {x1, y1}, 0);
    tick();

    // basic scan, three latencies
    scan(d1, d0, d3);
    chk("done_l1", d1, 202);
    chk("done_l0", d0, 201);
    chk("done_l3", d3, 204);
    wait_idle();
    rd(3, 7);
    chk("rd37_l1", r1, 2);
    chk("rd37_l0", r0, 2);
    chk("rd37_l3", r3, 2);
    rd(9, 19);
    chk("rd919_l1", r1, 4);
    chk("rd919_l0", r0, 4);
    chk("rd919_l3", r3, 4);
    rd(10, 0);
    chk("rd_xoor", r1, 0);
    rd(0, 20);
    chk("rd_yoor", r1, 0);

    // front stays stable while the back bank fills
    mode = 1'b1;
    rd(3, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 1'b0;
    da = 0;
    for (int c = 1; c <= 400; c++) begin
      if (r1 != 3'd2) bad = 1'b1;
      if (done1) begin
        da = c;
        break;
      end
      tick();
    end
    chk("hold_front", {31'd0, bad}, 0);
    chk("done_t3", da, 202);
    tick();
    chk("swap_old", r1, 2);
    tick();
    chk("new_front", r1, 7);
    wait_idle();

    // start mid-scan queues exactly one more scan
    start = 1'b1;
    tick();
    start = 1'b0;
    da = 0;
    db = 0;
    for (int c = 1; c <= 600; c++) begin
      start = (c == 50);
      if (done1 && da == 0) da = c;
      else if (done1 && db == 0) db = c;
      if (da != 0 && c == da + 1) chk("pend_busy", busy1, 1);
      if (db != 0) break;
      tick();
    end
    start = 1'b0;
    chk("pend_d1", da, 202);
    chk("pend_gap", db - da, 202);
    tick();
    chk("pend_end", busy1, 0);
    wait_idle();

    mode = 1'b0;
    scan(d1, d0, d3);
    chk("pre_rst", d1, 202);
    wait_idle();

    // async abort at cycle 100
    rd_x = 4'd9;
    rd_y = 5'd19;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    chk("mid_busy", busy1, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_xy", {x1, y1}, 0);
    chk("abort_done", done1, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("abort_front", r1, 7);

    scan(d1, d0, d3);
    chk("post_l1", d1, 202);
    chk("post_l3", d3, 204);
    wait_idle();
    rd(3, 7);
    chk("post_rd37", r1, 2);
    rd(9, 19);
    chk("post_rd919", r1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
